// File: rtl/sisc_pkg.sv
// Shared SISC definitions: default word sizes, opcodes and the fetch state encoding.
`ifndef SISC_OPCODE
`define SISC_OPCODE(w) w[31:28]
`endif

package sisc_pkg;

    localparam int unsigned DEF_WIDTH    = 32;
    localparam int unsigned DEF_ADDRSIZE = 12;
    localparam int unsigned DEF_DEPTH    = 4;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_STA = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_JMP = 4'b0101;
    localparam logic [3:0] OP_JZ  = 4'b0110;
    localparam logic [3:0] OP_OR  = 4'b0111;
    localparam logic [3:0] OP_AND = 4'b1000;
    localparam logic [3:0] OP_HLT = 4'b1001;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        STOP  = 2'd2
    } fetch_state_t;

    function automatic logic is_hlt(input logic [DEF_WIDTH-1:0] w);
        return `SISC_OPCODE(w) == OP_HLT;
    endfunction

endpackage

// File: rtl/sisc_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory read port, instruction handoff and redirect.
interface sisc_fetch_unit_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ADDRSIZE = 12
);
    logic                imem_req;
    logic [ADDRSIZE-1:0] imem_addr;
    logic                imem_ack;
    logic [WIDTH-1:0]    imem_rdata;
    logic                ir_valid;
    logic [WIDTH-1:0]    ir_data;
    logic [ADDRSIZE-1:0] ir_pc;
    logic                ir_ready;
    logic                redirect;
    logic [ADDRSIZE-1:0] redirect_pc;
    logic                halted;

    modport master (
        output imem_req, imem_addr, ir_valid, ir_data, ir_pc, halted,
        input  imem_ack, imem_rdata, ir_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, ir_valid, ir_data, ir_pc, halted,
        output imem_ack, imem_rdata, ir_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/sisc_fetch_fifo.sv
// Prefetch FIFO holding {pc, instruction}; the head is kept in a register so it
// holds its last value when the FIFO drains.
module sisc_fetch_fifo #(
    parameter int unsigned DW    = 44,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned PW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [PW-1:0] count
);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, count_q;
    logic [PW-1:0] rd_nxt, count_popped, count_nxt;
    logic          do_push, do_pop;
    logic [DW-1:0] head_nxt;

    // Pop is applied before a flush; a flush discards any push in the same cycle.
    always_comb begin
        do_pop       = pop && !empty;
        do_push      = push && !flush;
        rd_nxt       = rd_ptr + PW'(do_pop);
        count_popped = count_q - PW'(do_pop);
        count_nxt    = flush ? '0 : count_popped + PW'(do_push);
        head_nxt     = rdata;
        if (count_nxt != '0)
            head_nxt = (count_popped == '0) ? wdata : mem[rd_nxt[AW-1:0]];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
            rdata   <= '0;
        end else begin
            wr_ptr  <= wr_ptr + PW'(do_push);
            rd_ptr  <= flush ? wr_ptr : rd_nxt;
            count_q <= count_nxt;
            empty   <= (count_nxt == '0);
            full    <= (count_nxt == PW'(DEPTH));
            rdata   <= head_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign count = count_q;

endmodule

// File: rtl/sisc_fetch_unit.sv
// SISC instruction fetch: single-outstanding memory reads into a prefetch FIFO,
// with branch redirect/flush and stop-on-HLT.
module sisc_fetch_unit
    import sisc_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned ADDRSIZE = DEF_ADDRSIZE,
    parameter int unsigned DEPTH    = DEF_DEPTH
) (
    input logic               clk,
    input logic               reset_n,
    sisc_fetch_unit_if.master bus
);

    localparam int unsigned PW = $clog2(DEPTH) + 1;
    localparam int unsigned EW = ADDRSIZE + WIDTH;

    fetch_state_t        state, state_nxt;
    logic                req_q, req_nxt;
    logic [ADDRSIZE-1:0] addr_q, addr_nxt;
    logic [ADDRSIZE-1:0] fetch_pc, fetch_pc_nxt;
    logic                discard, discard_nxt;
    logic                halted_q, halted_nxt;

    logic                fifo_full, fifo_empty;
    logic [PW-1:0]       fifo_count;
    logic [EW-1:0]       head;
    logic                pop, push, hlt_ack, space;
    logic [PW-1:0]       occ_after, count_nxt;

    // Occupancy after this cycle's push/pop decides whether another read may issue.
    assign pop       = !fifo_empty && bus.ir_ready;
    assign push      = (state == WAIT) && bus.imem_ack && !discard && !bus.redirect && !fifo_full;
    assign hlt_ack   = push && is_hlt(bus.imem_rdata);
    assign occ_after = fifo_count + PW'(push) - PW'(pop);
    assign space     = occ_after < PW'(DEPTH);
    assign count_nxt = bus.redirect ? '0 : occ_after;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= FETCH;
            req_q    <= 1'b0;
            addr_q   <= '0;
            fetch_pc <= '0;
            discard  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            req_q    <= req_nxt;
            addr_q   <= addr_nxt;
            fetch_pc <= fetch_pc_nxt;
            discard  <= discard_nxt;
            halted_q <= halted_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH: if (bus.redirect || space) state_nxt = WAIT;
            WAIT: begin
                if (bus.imem_ack) begin
                    if (bus.redirect)  state_nxt = WAIT;
                    else if (discard)  state_nxt = FETCH;
                    else if (hlt_ack)  state_nxt = STOP;
                    else if (space)    state_nxt = WAIT;
                    else               state_nxt = FETCH;
                end
            end
            STOP: if (bus.redirect) state_nxt = WAIT;
            default: state_nxt = FETCH;
        endcase
    end

    // The address register only moves once the outstanding read has been acked.
    always_comb begin
        req_nxt      = (state_nxt == WAIT);
        fetch_pc_nxt = fetch_pc;
        if (bus.redirect)
            fetch_pc_nxt = bus.redirect_pc;
        else if (push)
            fetch_pc_nxt = addr_q + ADDRSIZE'(1);
        addr_nxt = ((state == WAIT) && !bus.imem_ack) ? addr_q : fetch_pc_nxt;
        discard_nxt = discard;
        if (state == WAIT) begin
            if (bus.imem_ack)
                discard_nxt = 1'b0;
            else if (bus.redirect)
                discard_nxt = 1'b1;
        end
        halted_nxt = (state_nxt == STOP) && (count_nxt == '0);
    end

    sisc_fetch_fifo #(
        .DW    (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (bus.redirect),
        .wdata   ({addr_q, bus.imem_rdata}),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = addr_q;
    assign bus.ir_valid  = !fifo_empty;
    assign bus.ir_pc     = head[EW-1:WIDTH];
    assign bus.ir_data   = head[WIDTH-1:0];
    assign bus.halted    = halted_q;

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Bench for sisc_fetch_unit: directed scenarios plus randomized traffic checked
// against a rule-level model of the fetch stream.
module tb_sisc_fetch_unit;
    import sisc_pkg::*;

    localparam int unsigned W = 32;
    localparam int unsigned A = 12;
    localparam int unsigned D = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    sisc_fetch_unit_if #(.WIDTH(W), .ADDRSIZE(A)) bus ();

    sisc_fetch_unit #(.WIDTH(W), .ADDRSIZE(A), .DEPTH(D)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mem [4096];

    // model of the architectural stream
    int         m_occ;
    logic [A-1:0] m_exp_pc, m_fetch, m_prev_addr;
    logic       m_stopped, m_disc, m_req_exp, m_hold;

    // memory responder knobs
    int lat, fix_delay, max_delay, rdy_mode, ack_cnt;
    logic [A-1:0] acc_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_occ = 0; m_exp_pc = '0; m_fetch = '0; m_prev_addr = '0;
        m_stopped = 1'b0; m_disc = 1'b0; m_req_exp = 1'b0; m_hold = 1'b0;
        lat = 0; ack_cnt = 0;
        acc_q.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.ir_ready = 1'b0;
        bus.redirect = 1'b0; bus.redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", bus.imem_req, 0);
        chk("rst_addr", bus.imem_addr, 0);
        chk("rst_valid", bus.ir_valid, 0);
        chk("rst_data", bus.ir_data, 0);
        chk("rst_pc", bus.ir_pc, 0);
        chk("rst_halted", bus.halted, 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    // One clock cycle: respond as memory, check outputs against the model, advance.
    task automatic cycle();
        logic req, ack, rdy, pop, acc, hlt, disc_old, out_n, discarded;
        logic [A-1:0] addr;
        int occ_n;
        req  = bus.imem_req;
        addr = bus.imem_addr;
        if (req && !m_hold)
            lat = (fix_delay >= 0) ? fix_delay : int'($urandom_range(max_delay, 0));
        ack = req && (lat == 0);
        if (req && lat > 0) lat--;
        case (rdy_mode)
            0:       rdy = 1'b0;
            1:       rdy = 1'b1;
            default: rdy = 1'($urandom_range(1, 0));
        endcase
        bus.imem_ack   = ack;
        bus.imem_rdata = ack ? mem[addr] : $urandom;
        bus.ir_ready   = rdy;
        #1;
        chk("req", req, m_req_exp);
        if (req) chk("addr", addr, m_hold ? m_prev_addr : m_fetch);
        chk("valid", bus.ir_valid, m_occ != 0);
        if (m_occ != 0) begin
            chk("ir_pc", bus.ir_pc, m_exp_pc);
            chk("ir_data", bus.ir_data, mem[m_exp_pc]);
        end
        chk("halted", bus.halted, m_stopped && (m_occ == 0));
        chk("no_push_full", dut.u_fifo.push && dut.u_fifo.full, 0);

        pop       = (m_occ != 0) && rdy;
        disc_old  = m_disc;
        acc       = req && ack && !disc_old && !bus.redirect;
        discarded = req && ack && disc_old && !bus.redirect;
        hlt       = acc && (mem[addr][31:28] == OP_HLT);
        if (ack) ack_cnt++;
        if (acc) acc_q.push_back(addr);
        if (pop) m_exp_pc = m_exp_pc + A'(1);
        occ_n = m_occ + (acc ? 1 : 0) - (pop ? 1 : 0);
        if (acc) m_fetch = addr + A'(1);
        out_n = req && !ack;
        if (ack) m_disc = 1'b0;
        if (bus.redirect) begin
            occ_n = 0;
            m_exp_pc = bus.redirect_pc;
            m_fetch = bus.redirect_pc;
            m_stopped = 1'b0;
            if (out_n) m_disc = 1'b1;
        end else if (hlt) begin
            m_stopped = 1'b1;
        end
        if (out_n)             m_req_exp = 1'b1;
        else if (bus.redirect) m_req_exp = 1'b1;
        else if (m_stopped)    m_req_exp = 1'b0;
        else if (discarded)    m_req_exp = 1'b0;
        else                   m_req_exp = (occ_n < int'(D));
        m_hold = out_n;
        m_prev_addr = addr;
        m_occ = occ_n;
        @(posedge clk);
        #1;
        bus.redirect = 1'b0;
    endtask

    initial begin
        logic [W-1:0] w;
        logic got, found;
        int maxa;
        for (int i = 0; i < 4096; i++) begin
            w = $urandom;
            if (w[31:28] == OP_HLT) w[31:28] = OP_NOP;
            mem[i] = w;
        end
        fix_delay = 0; max_delay = 0; rdy_mode = 1;
        bus.redirect = 1'b0;

        // Streaming with same-cycle ack: pc 0,1,2... from two cycles after release.
        do_reset();
        fix_delay = 0; rdy_mode = 1;
        for (int c = 0; c < 14; c++) begin
            if (c >= 2) begin
                chk("a_valid", bus.ir_valid, 1);
                chk("a_pc", bus.ir_pc, 64'(c - 2));
            end
            cycle();
        end

        // Back-pressure: exactly DEPTH reads, then one pop allows one more.
        do_reset();
        fix_delay = 0; rdy_mode = 0;
        repeat (10) cycle();
        chk("b_reqs", 64'(ack_cnt), 64'(D));
        chk("b_req_low", bus.imem_req, 0);
        rdy_mode = 1;
        cycle();
        rdy_mode = 0;
        chk("b_reissue", bus.imem_req, 1);
        chk("b_reissue_addr", bus.imem_addr, 64'(D));
        repeat (4) cycle();

        // Redirect while a slow read is outstanding: stale word dropped.
        do_reset();
        fix_delay = 3; rdy_mode = 1;
        repeat (2) cycle();
        bus.redirect = 1'b1; bus.redirect_pc = A'(12'h100);
        cycle();
        got = 1'b0; found = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (bus.imem_req && !found && bus.imem_addr != '0) begin
                found = 1'b1;
                chk("c_next_addr", bus.imem_addr, 64'h100);
            end
            if (bus.ir_valid && !got) begin
                got = 1'b1;
                chk("c_first_pc", bus.ir_pc, 64'h100);
            end
            cycle();
        end
        chk("c_seen", {found, got}, 2'b11);

        // HLT at address 5 stops fetching; redirect resumes.
        do_reset();
        mem[5] = 32'h9000_0000;
        fix_delay = 0; rdy_mode = 1; maxa = 0;
        for (int c = 0; c < 15; c++) begin
            if (bus.imem_req && int'(bus.imem_addr) > maxa) maxa = int'(bus.imem_addr);
            cycle();
        end
        chk("d_maxaddr", 64'(maxa), 5);
        chk("d_halted", bus.halted, 1);
        bus.redirect = 1'b1; bus.redirect_pc = '0;
        cycle();
        chk("d_unhalt", bus.halted, 0);
        chk("d_resume", {bus.imem_req, bus.imem_addr}, {1'b1, 12'h000});
        repeat (4) cycle();

        // Address wrap from 0xFFF to 0x000.
        do_reset();
        w = $urandom;
        w[31:28] = OP_ADD;
        mem[5] = w;
        fix_delay = 0; rdy_mode = 1;
        bus.redirect = 1'b1; bus.redirect_pc = A'(12'hFFE);
        cycle();
        repeat (8) cycle();
        found = 1'b0;
        for (int i = 0; i + 1 < acc_q.size(); i++) begin
            if (acc_q[i] == A'(12'hFFF)) begin
                found = 1'b1;
                chk("e_wrap", acc_q[i+1], 0);
            end
        end
        chk("e_found", found, 1);

        // Randomized traffic with random latency, back-pressure, redirects and HLTs.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            w = mem[$urandom_range(4095, 0)];
            w = {OP_HLT, w[27:0]};
            mem[$urandom_range(4095, 0)] = w;
        end
        fix_delay = -1; max_delay = 3; rdy_mode = 2;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(15, 0) == 0) begin
                bus.redirect = 1'b1;
                bus.redirect_pc = A'($urandom);
            end
            cycle();
        end

        // Reset while a read is outstanding and the FIFO holds two entries.
        do_reset();
        fix_delay = 0; rdy_mode = 0; found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (m_occ == 2 && bus.imem_req) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
        chk("f_setup", found, 1);
        reset_n = 1'b0;
        #1;
        chk("f_req", bus.imem_req, 0);
        chk("f_addr", bus.imem_addr, 0);
        chk("f_valid", bus.ir_valid, 0);
        chk("f_data", bus.ir_data, 0);
        chk("f_pc", bus.ir_pc, 0);
        chk("f_halted", bus.halted, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
